// File: rtl/sad_search_ctrl.sv
// Block-matching search sequencer: launches one SAD per candidate and tracks the minimum.
// Optional per-candidate watchdog enabled by defining SAD_SEARCH_TIMEOUT_EN.
`timescale 1ns/1ps
module sad_search_ctrl #(
  parameter int unsigned SAD_W       = 32,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       num_cand,
  output logic             sad_go,
  output logic [7:0]       cand_idx,
  input  logic             sad_done,
  input  logic [SAD_W-1:0] sad_val,
  output logic             busy,
  output logic             done,
  output logic [SAD_W-1:0] best_sad,
  output logic [7:0]       best_idx,
  output logic             found,
  output logic             err
);

  localparam int unsigned IDX_W = 8;

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_FIN} state_t;

  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 1");
  end

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   num_q, num_d;
  logic [IDX_W-1:0]   cand_idx_q, cand_idx_d;
  logic [SAD_W-1:0]   best_sad_q, best_sad_d;
  logic [IDX_W-1:0]   best_idx_q, best_idx_d;
  logic               found_q, found_d;
  logic               err_q, err_d;
  logic               sad_go_q, sad_go_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               timeout_c;

`ifdef SAD_SEARCH_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counts WAIT cycles for the candidate in flight
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_LAUNCH) begin
      cnt_d = '0;
    end else if (state_q == S_WAIT) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign timeout_c = (state_q == S_WAIT) && !sad_done &&
                     (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign timeout_c = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    num_d      = num_q;
    cand_idx_d = cand_idx_q;
    best_sad_d = best_sad_q;
    best_idx_d = best_idx_q;
    found_d    = found_q;
    err_d      = err_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          num_d      = num_cand;
          cand_idx_d = '0;
          best_sad_d = '1;
          best_idx_d = '0;
          found_d    = 1'b0;
          err_d      = 1'b0;
          state_d    = (num_cand == '0) ? S_FIN : S_LAUNCH;
        end
      end
      S_LAUNCH: state_d = S_WAIT;
      S_WAIT: begin
        if (sad_done) begin
          // Strict compare keeps the earliest index on ties
          if (!found_q || (sad_val < best_sad_q)) begin
            best_sad_d = sad_val;
            best_idx_d = cand_idx_q;
          end
          found_d = 1'b1;
          if (cand_idx_q == num_q - IDX_W'(1)) begin
            state_d = S_FIN;
          end else begin
            cand_idx_d = cand_idx_q + IDX_W'(1);
            state_d    = S_LAUNCH;
          end
        end else if (timeout_c) begin
          err_d   = 1'b1;
          state_d = S_FIN;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    sad_go_d = (state_d == S_LAUNCH);
    busy_d   = (state_d != S_IDLE);
    // An empty search spends its single busy cycle in FIN; done follows one cycle later
    done_d   = ((state_q == S_WAIT) && (state_d == S_FIN)) ||
               ((state_q == S_FIN) && !done_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      num_q      <= '0;
      cand_idx_q <= '0;
      best_sad_q <= '1;
      best_idx_q <= '0;
      found_q    <= 1'b0;
      err_q      <= 1'b0;
      sad_go_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      num_q      <= num_d;
      cand_idx_q <= cand_idx_d;
      best_sad_q <= best_sad_d;
      best_idx_q <= best_idx_d;
      found_q    <= found_d;
      err_q      <= err_d;
      sad_go_q   <= sad_go_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign sad_go   = sad_go_q;
  assign cand_idx = cand_idx_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign best_sad = best_sad_q;
  assign best_idx = best_idx_q;
  assign found    = found_q;
  assign err      = err_q;

endmodule

// File: tb/tb_sad_search_ctrl.sv
// Directed bench for sad_search_ctrl: behavioural SAD engine with fixed latency.
`timescale 1ns/1ps
module tb_sad_search_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  num_cand;
  logic        sad_go;
  logic [7:0]  cand_idx;
  logic        sad_done;
  logic [31:0] sad_val;
  logic        busy;
  logic        done;
  logic [31:0] best_sad;
  logic [7:0]  best_idx;
  logic        found;
  logic        err;

  int total = 0;
  int bad   = 0;

  logic [31:0] sad_tab [0:3];
  int go_cnt, done_cnt, done_cyc, busy_cnt, busy_after;

  always #5 clk = ~clk;

  sad_search_ctrl #(.SAD_W(32), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst(rst), .start(start), .num_cand(num_cand),
    .sad_go(sad_go), .cand_idx(cand_idx), .sad_done(sad_done), .sad_val(sad_val),
    .busy(busy), .done(done), .best_sad(best_sad), .best_idx(best_idx),
    .found(found), .err(err)
  );

  // Cycle 0 carries start; cycle c outputs are sampled at the negedge inside it.
  task automatic run(input int n, input int lat, input int hang, input bit spam,
                     input bit spurious, input int max_c);
    int pend;
    int nxt;
    pend = -1; nxt = 0;
    go_cnt = 0; done_cnt = 0; done_cyc = -1; busy_cnt = 0; busy_after = -1;
    @(negedge clk);
    start = 1'b1; num_cand = 8'(n); sad_done = 1'b0;
    for (int c = 1; c <= max_c; c++) begin
      @(negedge clk);
      sad_done = 1'b0;
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (done_cyc >= 0 && c == done_cyc + 1) busy_after = int'(busy);
      if (sad_go) begin
        if (go_cnt != hang) pend = c + lat;
        go_cnt++;
        if (spurious) begin sad_done = 1'b1; sad_val = 32'd0; end
      end
      if (c == pend) begin
        sad_done = 1'b1; sad_val = sad_tab[nxt]; nxt++;
      end
      start = spam && (done_cyc < 0 || c == done_cyc);
      if (done_cyc >= 0 && c >= done_cyc + 2) break;
    end
    start = 1'b0; sad_done = 1'b0;
  endtask

  task automatic test_reset();
    total++; if (sad_go !== 1'b0) begin bad++; $display("FAIL reset_sad_go got=%0h exp=0", sad_go); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0h exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0h exp=0", done); end
    total++; if (cand_idx !== 8'd0) begin bad++; $display("FAIL reset_cand_idx got=%0h exp=0", cand_idx); end
    total++; if (best_sad !== 32'hFFFF_FFFF) begin bad++; $display("FAIL reset_best_sad got=%0h exp=ffffffff", best_sad); end
    total++; if (best_idx !== 8'd0) begin bad++; $display("FAIL reset_best_idx got=%0h exp=0", best_idx); end
    total++; if (found !== 1'b0) begin bad++; $display("FAIL reset_found got=%0h exp=0", found); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%0h exp=0", err); end
  endtask

  task automatic test_four_cand();
    sad_tab[0] = 32'd50; sad_tab[1] = 32'd20; sad_tab[2] = 32'd20; sad_tab[3] = 32'd70;
    run(4, 3, -1, 1'b0, 1'b0, 60);
    total++; if (best_sad !== 32'd20) begin bad++; $display("FAIL four_best_sad got=%0d exp=20", best_sad); end
    total++; if (best_idx !== 8'd1) begin bad++; $display("FAIL four_best_idx got=%0d exp=1", best_idx); end
    total++; if (found !== 1'b1) begin bad++; $display("FAIL four_found got=%0h exp=1", found); end
    total++; if (done_cyc != 17) begin bad++; $display("FAIL four_done_cycle got=%0d exp=17", done_cyc); end
    total++; if (go_cnt != 4) begin bad++; $display("FAIL four_go_count got=%0d exp=4", go_cnt); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL four_done_count got=%0d exp=1", done_cnt); end
    total++; if (busy_cnt != 17) begin bad++; $display("FAIL four_busy_cycles got=%0d exp=17", busy_cnt); end
    total++; if (busy_after != 0) begin bad++; $display("FAIL four_busy_after_done got=%0d exp=0", busy_after); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL four_err got=%0h exp=0", err); end
  endtask

  task automatic test_zero_cand();
    run(0, 3, -1, 1'b0, 1'b0, 20);
    total++; if (done_cyc != 2) begin bad++; $display("FAIL zero_done_cycle got=%0d exp=2", done_cyc); end
    total++; if (busy_cnt != 1) begin bad++; $display("FAIL zero_busy_cycles got=%0d exp=1", busy_cnt); end
    total++; if (go_cnt != 0) begin bad++; $display("FAIL zero_go_count got=%0d exp=0", go_cnt); end
    total++; if (found !== 1'b0) begin bad++; $display("FAIL zero_found got=%0h exp=0", found); end
    total++; if (best_sad !== 32'hFFFF_FFFF) begin bad++; $display("FAIL zero_best_sad got=%0h exp=ffffffff", best_sad); end
  endtask

  task automatic test_single_max();
    sad_tab[0] = 32'hFFFF_FFFF;
    run(1, 2, -1, 1'b0, 1'b0, 30);
    total++; if (best_sad !== 32'hFFFF_FFFF) begin bad++; $display("FAIL single_best_sad got=%0h exp=ffffffff", best_sad); end
    total++; if (best_idx !== 8'd0) begin bad++; $display("FAIL single_best_idx got=%0d exp=0", best_idx); end
    total++; if (found !== 1'b1) begin bad++; $display("FAIL single_found got=%0h exp=1", found); end
    total++; if (done_cyc != 4) begin bad++; $display("FAIL single_done_cycle got=%0d exp=4", done_cyc); end
  endtask

  task automatic test_back_to_back();
    sad_tab[0] = 32'd30; sad_tab[1] = 32'd10; sad_tab[2] = 32'd40;
    run(3, 2, -1, 1'b1, 1'b1, 60);
    total++; if (go_cnt != 3) begin bad++; $display("FAIL b2b_go_count got=%0d exp=3", go_cnt); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL b2b_done_count got=%0d exp=1", done_cnt); end
    total++; if (done_cyc != 10) begin bad++; $display("FAIL b2b_done_cycle got=%0d exp=10", done_cyc); end
    total++; if (best_sad !== 32'd10) begin bad++; $display("FAIL b2b_best_sad got=%0d exp=10", best_sad); end
    total++; if (best_idx !== 8'd1) begin bad++; $display("FAIL b2b_best_idx got=%0d exp=1", best_idx); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_busy_idle got=%0h exp=0", busy); end
  endtask

  task automatic test_mid_reset();
    sad_tab[0] = 32'd40; sad_tab[1] = 32'd15;
    run(3, 3, 2, 1'b0, 1'b0, 11);
    total++; if (best_sad !== 32'd15) begin bad++; $display("FAIL rst_pre_best_sad got=%0d exp=15", best_sad); end
    rst = 1'b1;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0h exp=0", busy); end
    total++; if (cand_idx !== 8'd0) begin bad++; $display("FAIL rst_cand_idx got=%0d exp=0", cand_idx); end
    total++; if (best_sad !== 32'hFFFF_FFFF) begin bad++; $display("FAIL rst_best_sad got=%0h exp=ffffffff", best_sad); end
    total++; if (best_idx !== 8'd0) begin bad++; $display("FAIL rst_best_idx got=%0d exp=0", best_idx); end
    total++; if (found !== 1'b0) begin bad++; $display("FAIL rst_found got=%0h exp=0", found); end
    @(negedge clk);
    rst = 1'b0; sad_done = 1'b1; sad_val = 32'd1;
    @(negedge clk);
    sad_done = 1'b0;
    total++; if (found !== 1'b0) begin bad++; $display("FAIL late_found got=%0h exp=0", found); end
    total++; if (best_sad !== 32'hFFFF_FFFF) begin bad++; $display("FAIL late_best_sad got=%0h exp=ffffffff", best_sad); end
    total++; if (busy !== 1'b0 || sad_go !== 1'b0) begin bad++; $display("FAIL late_busy_go got=%0h%0h exp=00", busy, sad_go); end
    sad_tab[0] = 32'd9; sad_tab[1] = 32'd3;
    run(2, 2, -1, 1'b0, 1'b0, 40);
    total++; if (best_sad !== 32'd3) begin bad++; $display("FAIL post_rst_best_sad got=%0d exp=3", best_sad); end
    total++; if (best_idx !== 8'd1) begin bad++; $display("FAIL post_rst_best_idx got=%0d exp=1", best_idx); end
    total++; if (done_cyc != 7) begin bad++; $display("FAIL post_rst_done_cycle got=%0d exp=7", done_cyc); end
  endtask

`ifdef SAD_SEARCH_TIMEOUT_EN
  task automatic test_timeout();
    sad_tab[0] = 32'd7;
    run(3, 2, 1, 1'b0, 1'b0, 100);
    total++; if (err !== 1'b1) begin bad++; $display("FAIL to_err got=%0h exp=1", err); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL to_done_count got=%0d exp=1", done_cnt); end
    total++; if (go_cnt != 2) begin bad++; $display("FAIL to_go_count got=%0d exp=2", go_cnt); end
    total++; if (best_idx !== 8'd0) begin bad++; $display("FAIL to_best_idx got=%0d exp=0", best_idx); end
    total++; if (best_sad !== 32'd7) begin bad++; $display("FAIL to_best_sad got=%0d exp=7", best_sad); end
  endtask
`endif

  initial begin
    rst = 1'b1; start = 1'b0; num_cand = 8'd0; sad_done = 1'b0; sad_val = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_four_cand();
    test_zero_cand();
    test_single_max();
    test_back_to_back();
    test_mid_reset();
`ifdef SAD_SEARCH_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
